// File: rtl/sram_req_ctrl_pkg.sv
// Shared constants and helpers for the SRAM request controller and its response FIFO.
// The response record is packed as {err, rdata}: err sits directly above the data bits.
package sram_req_ctrl_pkg;

   localparam int unsigned DEPTH_DEF     = 8;
   localparam int unsigned WIDTH_DEF     = 4;
   localparam int unsigned RSP_DEPTH_DEF = 3;
   localparam int unsigned RSP_DEPTH_MIN = 2;

   function automatic int unsigned addr_w(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int unsigned rsp_w(input int unsigned width);
      return width + 1;
   endfunction

endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and sram_req_ctrl (slave).
interface sram_req_ctrl_if
   import sram_req_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = addr_w(DEPTH_DEF),
   parameter int unsigned WIDTH  = WIDTH_DEF
);

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [WIDTH-1:0]  req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [WIDTH-1:0]  rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO for read responses; head entry is read straight from its storage register.
// Push and pop may coincide at any occupancy, including full.
module sram_rsp_fifo
   import sram_req_ctrl_pkg::*;
#(
   parameter  int unsigned DEPTH = RSP_DEPTH_DEF,
   parameter  int unsigned W     = rsp_w(WIDTH_DEF),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     din,
   input  logic             pop,
   output logic [W-1:0]     dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Pointer and occupancy state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage carries no reset; only the pointers define what is live
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (cnt == CNT_W'(DEPTH));
   assign empty = (cnt == '0);
   assign count = cnt;

endmodule

// File: rtl/sram_req_ctrl.sv
// Front end for a single-port synchronous SRAM: turns a valid/ready request stream into
// one-cycle we/re strobes, captures registered read data and returns it through a response FIFO.
module sram_req_ctrl
   import sram_req_ctrl_pkg::*;
#(
   parameter  int unsigned depth     = DEPTH_DEF,
   parameter  int unsigned width     = WIDTH_DEF,
   parameter  int unsigned rsp_depth = RSP_DEPTH_DEF,
   localparam int unsigned ADDR_W    = addr_w(depth)
) (
   input  logic              clk,
   input  logic              rst,
   sram_req_ctrl_if.slave    bus,
   output logic              wr_err,
   output logic              sram_we,
   output logic              sram_re,
   output logic [ADDR_W-1:0] sram_add,
   output logic [width-1:0]  sram_data_in,
   input  logic [width-1:0]  sram_data_out
);

   localparam int unsigned RSP_W = rsp_w(width);
   localparam int unsigned CNT_W = $clog2(rsp_depth + 1);

   if (rsp_depth < RSP_DEPTH_MIN) begin : g_bad_rsp_depth
      $error("sram_req_ctrl: rsp_depth below minimum");
   end

   logic             fire;
   logic             in_range;
   logic             rd_pend;
   logic             rd_err;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [RSP_W-1:0] push_rec;
   logic [RSP_W-1:0] head;

   // Flow gate counts the read still in the SRAM so the FIFO can never overflow
   assign bus.req_ready = !rst && ((32'(fifo_count) + 32'(rd_pend)) < rsp_depth);
   assign fire          = bus.req_valid && bus.req_ready;
   assign in_range      = 32'(bus.req_addr) < depth;

   // SRAM strobes are combinational so they land on the handshake edge
   assign sram_we      = fire && bus.req_write && in_range;
   assign sram_re      = fire && !bus.req_write && in_range;
   assign sram_add     = bus.req_addr;
   assign sram_data_in = bus.req_wdata;

   // Read-pending flag marks the cycle sram_data_out is driven; wr_err is sticky
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend <= 1'b0;
         rd_err  <= 1'b0;
         wr_err  <= 1'b0;
      end else begin
         rd_pend <= fire && !bus.req_write;
         rd_err  <= !in_range;
         if (fire && bus.req_write && !in_range) wr_err <= 1'b1;
      end
   end

   assign push_rec = rd_err ? {1'b1, {width{1'b0}}} : {1'b0, sram_data_out};
   assign pop      = bus.rsp_valid && bus.rsp_ready;

   sram_rsp_fifo #(
      .DEPTH (rsp_depth),
      .W     (RSP_W)
   ) u_rsp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rd_pend),
      .din   (push_rec),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.rsp_valid = !fifo_empty;
   assign bus.rsp_err   = head[width];
   assign bus.rsp_rdata = head[width-1:0];

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(rd_pend && fifo_full && !pop));

endmodule
